// File: rtl/op_out_pkg.sv
// Shared definitions for the op_out output stage.
//   - Default sizing constants for channel count, result width and FIFO depth.
//   - ch_idx_t: channel tag type at the default channel count.
//   - rr_search: round-robin search over a non-empty vector, starting at a pointer.
package op_out_pkg;

  localparam int unsigned OP_OUT_NUM_CH = 4;
  localparam int unsigned OP_OUT_DATA_W = 4;
  localparam int unsigned OP_OUT_DEPTH  = 4;

  // Widest channel count the search function handles.
  localparam int unsigned RR_MAX_CH = 32;

  typedef logic [$clog2(OP_OUT_NUM_CH)-1:0] ch_idx_t;

  // Returns 1 if any of the first num_ch bits of nonempty is set. grant is the first set
  // index found searching upward from ptr and wrapping at num_ch. Requires ptr < num_ch.
  function automatic logic rr_search(input  int unsigned          ptr,
                                     input  logic [RR_MAX_CH-1:0] nonempty,
                                     input  int unsigned          num_ch,
                                     output int unsigned          grant);
    logic        found;
    int unsigned j;
    found = 1'b0;
    grant = 0;
    for (int unsigned i = 0; i < RR_MAX_CH; i++) begin
      j = ptr + i;
      if (j >= num_ch) begin
        j = j - num_ch;
      end
      if (!found && (i < num_ch) && nonempty[j[4:0]]) begin
        found = 1'b1;
        grant = j;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/op_out_fifo.sv
// Single-clock synchronous FIFO buffering one operator channel.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; ignored when full unless popped the same cycle
//   pop, dout  : read request and head-of-queue data (dout valid while !empty)
//   full, empty: occupancy status
//   lvl        : current occupancy, 0..DEPTH
module op_out_fifo #(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned LW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     lvl
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  always_comb begin
    full    = (cnt_q == LW'(DEPTH));
    empty   = (cnt_q == '0);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    do_push = push && (!full || do_pop);
    // DEPTH is a power of two, so the pointers wrap naturally.
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + LW'(do_push) - LW'(do_pop);
    dout     = mem_q[rd_ptr_q];
    lvl      = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only observable through cnt_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/op_out_mux.sv
// Multi-channel output stage for the logic-op datapath. Each channel's results are buffered
// in a FIFO and merged round-robin onto one tagged valid/ready stream.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_data, in_en    : per-channel results and single-cycle strobes (no backpressure)
//   out_data, out_ch  : merged result and its source channel
//   out_en, out_rdy   : output valid / downstream ready; transfer when both are high
//   ovf, clr_ovf      : sticky per-channel drop flags and their clear
//   lvl               : per-channel FIFO occupancy
module op_out_mux
  import op_out_pkg::*;
#(
  parameter  int unsigned NUM_CH = OP_OUT_NUM_CH,
  parameter  int unsigned DATA_W = OP_OUT_DATA_W,
  parameter  int unsigned DEPTH  = OP_OUT_DEPTH,
  localparam int unsigned CH_W   = $clog2(NUM_CH),
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_en,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_en,
  input  logic                     out_rdy,
  output logic [NUM_CH-1:0]        ovf,
  input  logic                     clr_ovf,
  output logic [NUM_CH*LVL_W-1:0]  lvl
);

  logic [NUM_CH-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout [NUM_CH];

  logic [NUM_CH-1:0] ovf_q, ovf_d, ovf_set;
  logic              out_en_q, out_en_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              load_en;
  logic              grant_found;
  int unsigned       grant_idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    op_out_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (fifo_push[g]),
      .pop  (fifo_pop[g]),
      .din  (in_data[g*DATA_W +: DATA_W]),
      .dout (fifo_dout[g]),
      .full (fifo_full[g]),
      .empty(fifo_empty[g]),
      .lvl  (lvl[g*LVL_W +: LVL_W])
    );
  end

  always_comb begin
    load_en     = !out_en_q || out_rdy;
    grant_idx   = 0;
    grant_found = rr_search(32'(ptr_q), RR_MAX_CH'(~fifo_empty), NUM_CH, grant_idx);

    fifo_pop   = '0;
    ptr_d      = ptr_q;
    out_en_d   = out_en_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;

    if (load_en) begin
      // With nothing to send the bus goes idle but keeps its last data/tag.
      out_en_d = grant_found;
      if (grant_found) begin
        ptr_d = (grant_idx == NUM_CH - 1) ? '0 : CH_W'(grant_idx + 1);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (grant_idx == i) begin
            fifo_pop[i] = 1'b1;
            out_data_d  = fifo_dout[i];
            out_ch_d    = CH_W'(i);
          end
        end
      end
    end

    // The FIFO itself refuses a push when full and not popped; flag exactly that case.
    fifo_push = in_en;
    ovf_set   = in_en & fifo_full & ~fifo_pop;
    ovf_d     = ovf_set | (ovf_q & ~{NUM_CH{clr_ovf}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q      <= '0;
      out_en_q   <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      ptr_q      <= '0;
    end else begin
      ovf_q      <= ovf_d;
      out_en_q   <= out_en_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    out_en   = out_en_q;
    out_data = out_data_q;
    out_ch   = out_ch_q;
    ovf      = ovf_q;
  end

endmodule

// File: tb/tb_op_out_mux.sv
// Directed testbench for op_out_mux at its default sizing (4 channels, 4-bit data, depth 4).
module tb_op_out_mux;
  import op_out_pkg::*;

  localparam int unsigned NCH = OP_OUT_NUM_CH;
  localparam int unsigned DW  = OP_OUT_DATA_W;
  localparam int unsigned DEP = OP_OUT_DEPTH;
  localparam int unsigned CHW = $clog2(NCH);
  localparam int unsigned LW  = $clog2(DEP) + 1;

  logic              clk;
  logic              rst_n;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_en;
  logic [DW-1:0]     out_data;
  ch_idx_t           out_ch;
  logic              out_en;
  logic              out_rdy;
  logic [NCH-1:0]    ovf;
  logic              clr_ovf;
  logic [NCH*LW-1:0] lvl;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  op_out_mux #(
    .NUM_CH(NCH),
    .DATA_W(DW),
    .DEPTH (DEP)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_en   (in_en),
    .out_data(out_data),
    .out_ch  (out_ch),
    .out_en  (out_en),
    .out_rdy (out_rdy),
    .ovf     (ovf),
    .clr_ovf (clr_ovf),
    .lvl     (lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lvl_of(input int unsigned ch);
    return 32'(lvl[ch*LW +: LW]);
  endfunction

  // Advance one clock; inputs set before the call are sampled at this edge and outputs
  // are examined 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    in_en   = '0;
    in_data = '0;
    out_rdy = 1'b0;
    clr_ovf = 1'b0;
    #3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    in_en   = '0;
    in_data = '0;
    out_rdy = 1'b0;
    clr_ovf = 1'b0;
    #2;
    // Reset state
    check_eq("rst_out_en", 32'(out_en), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_out_ch", 32'(out_ch), 0);
    check_eq("rst_ovf", 32'(ovf), 0);
    check_eq("rst_lvl", 32'(lvl), 0);
    apply_reset();

    // Single result on ch1: visible exactly two edges after the strobe
    in_data = 16'h00A0;
    in_en   = 4'b0010;
    out_rdy = 1'b1;
    tick();
    check_eq("single_t1_out_en", 32'(out_en), 0);
    check_eq("single_t1_lvl1", lvl_of(1), 1);
    in_en = '0;
    tick();
    check_eq("single_t2_out_en", 32'(out_en), 1);
    check_eq("single_t2_data", 32'(out_data), 32'hA);
    check_eq("single_t2_ch", 32'(out_ch), 1);
    check_eq("single_t2_lvl1", lvl_of(1), 0);
    tick();
    check_eq("single_t3_out_en", 32'(out_en), 0);
    check_eq("single_ovf", 32'(ovf), 0);

    // Fairness: all channels strobed for 3 cycles, data = {ch, cycle}
    apply_reset();
    out_rdy = 1'b1;
    for (int unsigned c = 0; c < 14; c++) begin
      in_en = (c < 3) ? 4'hF : 4'h0;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        in_data[ch*DW +: DW] = 4'((ch << 2) | c);
      end
      tick();
      if (c >= 1 && c <= 12) begin
        int unsigned k;
        int unsigned ech;
        k   = c - 1;
        ech = k % 4;
        check_eq($sformatf("fair_en_%0d", k), 32'(out_en), 1);
        check_eq($sformatf("fair_ch_%0d", k), 32'(out_ch), ech);
        check_eq($sformatf("fair_data_%0d", k), 32'(out_data), (ech << 2) | (k / 4));
      end else if (c == 13) begin
        check_eq("fair_idle", 32'(out_en), 0);
      end
    end

    // Backpressure on ch0: head held, FIFO fills, sixth strobe dropped
    apply_reset();
    out_rdy = 1'b0;
    for (int unsigned k = 1; k <= 6; k++) begin
      in_en   = 4'b0001;
      in_data = 16'(k);
      tick();
      if (k >= 2) check_eq($sformatf("bp_hold_%0d", k), 32'(out_data), 1);
      if (k == 5) begin
        check_eq("bp_lvl0_full", lvl_of(0), 4);
        check_eq("bp_no_ovf_yet", 32'(ovf), 0);
      end
    end
    check_eq("bp_out_en", 32'(out_en), 1);
    check_eq("bp_lvl0", lvl_of(0), 4);
    check_eq("bp_ovf0", 32'(ovf), 1);
    in_en   = '0;
    out_rdy = 1'b1;
    for (int unsigned k = 2; k <= 5; k++) begin
      tick();
      check_eq($sformatf("bp_drain_en_%0d", k), 32'(out_en), 1);
      check_eq($sformatf("bp_drain_%0d", k), 32'(out_data), k);
    end
    tick();
    check_eq("bp_drain_idle", 32'(out_en), 0);
    check_eq("bp_ovf_sticky", 32'(ovf), 1);

    // Full ch2 FIFO accepts a push when popped in the same cycle
    apply_reset();
    out_rdy = 1'b0;
    for (int unsigned k = 1; k <= 5; k++) begin
      in_en   = 4'b0100;
      in_data = 16'(k << 8);
      tick();
    end
    check_eq("fp_lvl2_full", lvl_of(2), 4);
    check_eq("fp_head", 32'(out_data), 1);
    out_rdy = 1'b1;
    in_en   = 4'b0100;
    in_data = 16'(6 << 8);
    tick();
    check_eq("fp_lvl2_same", lvl_of(2), 4);
    check_eq("fp_ovf", 32'(ovf), 0);
    check_eq("fp_data", 32'(out_data), 2);
    check_eq("fp_ch", 32'(out_ch), 2);
    in_en = '0;
    for (int unsigned k = 3; k <= 6; k++) begin
      tick();
      check_eq($sformatf("fp_drain_%0d", k), 32'(out_data), k);
    end

    // Overflow set beats a simultaneous clear; a lone clear then clears
    apply_reset();
    out_rdy = 1'b0;
    for (int unsigned k = 1; k <= 6; k++) begin
      in_en   = 4'b1000;
      in_data = 16'(k << 12);
      tick();
    end
    check_eq("race_ovf_set", 32'(ovf), 32'h8);
    in_en   = 4'b1000;
    clr_ovf = 1'b1;
    tick();
    check_eq("race_set_wins", 32'(ovf), 32'h8);
    in_en = '0;
    tick();
    check_eq("race_clear", 32'(ovf), 0);
    clr_ovf = 1'b0;

    // Asynchronous reset in mid-traffic
    apply_reset();
    out_rdy = 1'b0;
    in_data = 16'h1234;
    for (int unsigned k = 0; k < 6; k++) begin
      in_en = 4'hF;
      tick();
    end
    in_en = '0;
    check_eq("mr_pre_ovf", 32'(ovf), 32'hF);
    check_eq("mr_pre_out_en", 32'(out_en), 1);
    check_eq("mr_pre_lvl", 32'(lvl), 32'h924);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_out_en", 32'(out_en), 0);
    check_eq("mr_lvl", 32'(lvl), 0);
    check_eq("mr_ovf", 32'(ovf), 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    in_en   = 4'hF;
    in_data = 16'hDCBA;
    out_rdy = 1'b1;
    tick();
    in_en = '0;
    tick();
    check_eq("mr_first_en", 32'(out_en), 1);
    check_eq("mr_first_ch", 32'(out_ch), 0);
    check_eq("mr_first_data", 32'(out_data), 32'hA);
    tick();
    check_eq("mr_second_ch", 32'(out_ch), 1);
    check_eq("mr_second_data", 32'(out_data), 32'hB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
